// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the program loader.
package prog_loader_pkg;
  localparam int DEF_ADDR_WIDTH  = 5;
  localparam int DEF_REG_BIT_CNT = 3;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_WORD_W      = DEF_ADDR_WIDTH + DEF_REG_BIT_CNT + DEF_DATA_WIDTH;
  localparam int BYTES_PER_WORD  = 3;
  localparam int HDR_WIDTH       = 8;
  localparam int CHK_WIDTH       = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_BYTE  = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;
endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write bus of the loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WORD_W     = DEF_WORD_W
);
  logic                  in_valid;
  logic [HDR_WIDTH-1:0]  in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_W-1:0]     mem_wdata;

  modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/prog_loader_word_packer.sv
// Shifts bytes MSB-first into an instruction word and flags the byte that completes it.
module word_packer #(
  parameter int WORD_W = 24,
  parameter int NBYTES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word,
  output logic              complete
);
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  // Only the low bytes need storing: the full word is visible as the last byte arrives.
  logic [WORD_W-9:0] shreg;
  logic [IDX_W-1:0]  idx;

  assign word     = {shreg, din};
  assign complete = shift && (idx == IDX_W'(NBYTES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shreg <= '0;
      idx   <= '0;
    end else if (shift) begin
      shreg <= word[WORD_W-9:0];
      idx   <= complete ? '0 : idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Loads a header/payload/checksum byte stream into program memory; holds the core in reset until verified.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int REG_BIT_CNT = DEF_REG_BIT_CNT,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  prog_loader_if.slave    bus,
  output logic            core_rst_n,
  output logic            done,
  output logic            err
);
  localparam int COMBINED_DATA = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH;
  localparam int CNT_W         = ADDR_WIDTH + 1;
  localparam int MAX_WORDS     = 1 << ADDR_WIDTH;

  state_t                   state;
  logic [CNT_W-1:0]         n_words;
  logic [CNT_W-1:0]         wcnt;
  logic [CHK_WIDTH-1:0]     csum;
  logic [COMBINED_DATA-1:0] pk_word;
  logic                     pk_complete;
  logic                     xfer;
  logic                     restart;
  logic                     hdr_ok;

  assign bus.in_ready = (state == S_HDR) || (state == S_BYTE) || (state == S_CHK);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign restart      = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  // Compared as an int so the full word count 2**ADDR_WIDTH stays legal.
  assign hdr_ok       = (bus.in_data != '0) && (int'(bus.in_data) <= MAX_WORDS);

  word_packer #(.WORD_W(COMBINED_DATA), .NBYTES(BYTES_PER_WORD)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (restart),
    .shift    (xfer && (state == S_BYTE)),
    .din      (bus.in_data),
    .word     (pk_word),
    .complete (pk_complete)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      n_words       <= '0;
      wcnt          <= '0;
      csum          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      core_rst_n    <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (restart) begin
            state      <= S_HDR;
            wcnt       <= '0;
            csum       <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
          end
        end
        S_HDR: begin
          if (xfer) begin
            if (hdr_ok) begin
              n_words <= bus.in_data[CNT_W-1:0];
              state   <= S_BYTE;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        S_BYTE: begin
          if (xfer) begin
            csum <= csum ^ bus.in_data;
            if (pk_complete) begin
              state         <= S_WRITE;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= wcnt[ADDR_WIDTH-1:0];
              bus.mem_wdata <= pk_word;
            end
          end
        end
        S_WRITE: begin
          wcnt  <= wcnt + CNT_W'(1);
          state <= (wcnt + CNT_W'(1) == n_words) ? S_CHK : S_BYTE;
        end
        S_CHK: begin
          if (xfer) begin
            if (bus.in_data == csum) begin
              state      <= S_DONE;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: nominal, checksum/header errors, full image, backpressure, mid-load reset.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic core_rst_n, done, err;

  prog_loader_if bus ();

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [4:0]  wa[$];
  logic [23:0] wd[$];

  always @(negedge clk) begin
    if (!rst && bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int t = 0; t < 100; t++) begin
      if (bus.in_ready) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL send_byte: byte %02h never accepted (in_ready stayed 0)", b);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 31'd0) begin
      errors++;
      $display("FAIL reset_bus: got rdy=%b we=%b addr=%0d wdata=%h, need all 0",
               bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if ({core_rst_n, done, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got core_rst_n/done/err=%b, need 000", {core_rst_n, done, err});
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_nominal();
    logic [7:0] p[6] = '{8'h0A, 8'h12, 8'h34, 8'h11, 8'hAB, 8'hCD};
    logic [7:0] cs = 8'h0A ^ 8'h12 ^ 8'h34 ^ 8'h11 ^ 8'hAB ^ 8'hCD;
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'd2);
    pulse_start();  // must be ignored while loading
    for (int i = 0; i < 3; i++) send_byte(p[i]);
    checks++;
    if ({bus.mem_we, bus.in_ready, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 5'd0, 24'h0A1234}) begin
      errors++;
      $display("FAIL nom_latency: got we=%b rdy=%b addr=%0d wdata=%h, need we=1 rdy=0 addr=0 wdata=0a1234",
               bus.mem_we, bus.in_ready, bus.mem_addr, bus.mem_wdata);
    end
    for (int i = 3; i < 6; i++) send_byte(p[i]);
    send_byte(cs);
    tick(1);
    checks++;
    if (wa.size() !== 2) begin
      errors++; $display("FAIL nom_count: got %0d writes, need 2", wa.size());
    end
    checks++;
    if (wa[0] !== 5'd0 || wd[0] !== 24'h0A1234 || wa[1] !== 5'd1 || wd[1] !== 24'h11ABCD) begin
      errors++;
      $display("FAIL nom_words: got %0d:%h %0d:%h, need 0:0a1234 1:11abcd", wa[0], wd[0], wa[1], wd[1]);
    end
    checks++;
    if ({done, core_rst_n, err} !== 3'b110) begin
      errors++; $display("FAIL nom_status: got done/core_rst_n/err=%b, need 110", {done, core_rst_n, err});
    end
  endtask

  task automatic test_bad_cs();
    logic [7:0] p[6] = '{8'h0A, 8'h12, 8'h34, 8'h11, 8'hAB, 8'hCD};
    logic [7:0] cs = 8'h0A ^ 8'h12 ^ 8'h34 ^ 8'h11 ^ 8'hAB ^ 8'hCD;
    wa.delete(); wd.delete();
    pulse_start();
    checks++;
    if ({done, core_rst_n, err} !== 3'b000) begin
      errors++; $display("FAIL restart_status: got done/core_rst_n/err=%b, need 000", {done, core_rst_n, err});
    end
    send_byte(8'd2);
    for (int i = 0; i < 6; i++) send_byte(p[i]);
    send_byte(cs ^ 8'h01);
    tick(1);
    checks++;
    if (wa.size() !== 2 || wd[0] !== 24'h0A1234 || wd[1] !== 24'h11ABCD) begin
      errors++; $display("FAIL badcs_words: got %0d writes (%h,%h), need 2 (0a1234,11abcd)", wa.size(), wd[0], wd[1]);
    end
    checks++;
    if ({done, core_rst_n, err} !== 3'b001) begin
      errors++; $display("FAIL badcs_status: got done/core_rst_n/err=%b, need 001", {done, core_rst_n, err});
    end
  endtask

  task automatic test_bad_hdr(input logic [7:0] h);
    int n0;
    pulse_start();
    n0 = wa.size();
    send_byte(h);
    checks++;
    if ({done, err, core_rst_n} !== 3'b010) begin
      errors++; $display("FAIL badhdr_%0d_status: got done/err/core_rst_n=%b, need 010", h, {done, err, core_rst_n});
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL badhdr_%0d_ready: cycle %0d got in_ready=%b, need 0", h, i, bus.in_ready);
      end
      tick(1);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (wa.size() !== n0) begin
      errors++; $display("FAIL badhdr_%0d_we: got %0d writes, need 0", h, wa.size() - n0);
    end
  endtask

  task automatic test_full();
    logic [23:0] exp_w[32];
    logic [7:0]  cs = 8'h00;
    logic [7:0]  b;
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'd32);
    for (int w = 0; w < 32; w++) begin
      for (int k = 0; k < 3; k++) begin
        b = 8'($urandom_range(0, 255));
        exp_w[w] = {exp_w[w][15:0], b};
        cs ^= b;
        tick($urandom_range(0, 2));
        send_byte(b);
      end
    end
    send_byte(cs);
    tick(1);
    checks++;
    if (wa.size() !== 32) begin
      errors++; $display("FAIL full_count: got %0d writes, need 32", wa.size());
    end
    for (int i = 0; i < 32 && i < wa.size(); i++) begin
      checks++;
      if (wa[i] !== 5'(i) || wd[i] !== exp_w[i]) begin
        errors++; $display("FAIL full_word%0d: got %0d:%h, need %0d:%h", i, wa[i], wd[i], i, exp_w[i]);
      end
    end
    checks++;
    if ({done, core_rst_n, err} !== 3'b110) begin
      errors++; $display("FAIL full_status: got done/core_rst_n/err=%b, need 110", {done, core_rst_n, err});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[11] = '{8'd3, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h7F, 8'h80, 8'hC3, 8'h00};
    int idx = 0;
    int cyc = 0;
    int we_seen = 0;
    for (int i = 1; i < 10; i++) s[10] ^= s[i];
    wa.delete(); wd.delete();
    pulse_start();
    bus.in_valid = 1'b1;
    while (idx < 11 && cyc < 200) begin
      bus.in_data = s[idx];
      if (bus.mem_we) begin
        we_seen++;
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_ready_in_write: got in_ready=%b during mem_we, need 0", bus.in_ready);
        end
      end
      if (bus.in_ready) idx++;
      tick(1);
      cyc++;
    end
    bus.in_valid = 1'b0;
    tick(1);
    checks++;
    if (idx !== 11) begin
      errors++; $display("FAIL b2b_timeout: got %0d bytes accepted, need 11", idx);
    end
    checks++;
    if (we_seen !== 3 || wa.size() !== 3) begin
      errors++; $display("FAIL b2b_count: got %0d strobes / %0d logged, need 3", we_seen, wa.size());
    end
    checks++;
    if (wd[0] !== 24'hDEADBE || wd[1] !== 24'hEF0102 || wd[2] !== 24'h7F80C3 || wa[2] !== 5'd2) begin
      errors++; $display("FAIL b2b_words: got %h %h %h (last addr %0d), need deadbe ef0102 7f80c3 (2)", wd[0], wd[1], wd[2], wa[2]);
    end
    checks++;
    if ({done, err} !== 2'b10) begin
      errors++; $display("FAIL b2b_status: got done/err=%b, need 10", {done, err});
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] p[6] = '{8'h0A, 8'h12, 8'h34, 8'h11, 8'hAB, 8'hCD};
    logic [7:0] cs = 8'h0A ^ 8'h12 ^ 8'h34 ^ 8'h11 ^ 8'hAB ^ 8'hCD;
    pulse_start();
    send_byte(8'd2);
    for (int i = 0; i < 3; i++) send_byte(p[i]);
    rst = 1'b1;
    tick(1);
    checks++;
    if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_rst_n, done, err} !== 34'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got rdy=%b we=%b addr=%0d wdata=%h crn/done/err=%b, need all 0",
               bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, {core_rst_n, done, err});
    end
    rst = 1'b0;
    tick(1);
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'd2);
    for (int i = 0; i < 6; i++) send_byte(p[i]);
    send_byte(cs);
    tick(1);
    checks++;
    if (wa.size() !== 2 || wd[0] !== 24'h0A1234 || wd[1] !== 24'h11ABCD || {done, core_rst_n, err} !== 3'b110) begin
      errors++;
      $display("FAIL rstmid_reload: got %0d writes (%h,%h) done/crn/err=%b, need 2 (0a1234,11abcd) 110",
               wa.size(), wd[0], wd[1], {done, core_rst_n, err});
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_bad_cs();
    test_bad_hdr(8'd0);
    test_bad_hdr(8'd33);
    test_full();
    test_back_to_back();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
